// File: rtl/quant_channel_scheduler.sv
// Round-robin front end that shares one quantize_pipeline among NCH channels,
// tracks channel tags through the pipeline and buffers results in a credit-limited FIFO.
module quant_channel_scheduler #(
    parameter int NCH        = 4,
    parameter int CHW        = 2,
    parameter int LAT        = 4,
    parameter int FIFO_DEPTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cfg_we,
    input  logic [CHW-1:0]     cfg_ch,
    input  logic [31:0]        cfg_scale,
    input  logic [7:0]         cfg_zp,
    input  logic               cfg_asym,
    input  logic [NCH-1:0]     req_valid,
    input  logic [NCH*32-1:0]  req_data,
    output logic [NCH-1:0]     req_ready,
    output logic               qp_ena,
    output logic [31:0]        qp_fp_in,
    output logic [31:0]        qp_scale,
    output logic [7:0]         qp_zp,
    output logic               qp_use_asym,
    input  logic [7:0]         qp_q_out,
    input  logic               qp_sat,
    input  logic               qp_out_valid,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [CHW-1:0]     res_ch,
    output logic [7:0]         res_q,
    output logic               res_sat,
    output logic               busy,
    output logic               err
);
    localparam logic [31:0] SCALE_ONE = 32'h3F80_0000;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int OW = $clog2(FIFO_DEPTH + LAT + 2);

    logic [31:0]    cfg_scale_r [NCH];
    logic [7:0]     cfg_zp_r    [NCH];
    logic           cfg_asym_r  [NCH];
    logic [CHW-1:0] rr_ptr;
    logic [CHW-1:0] issue_ch;
    logic           tag_v  [LAT];
    logic [CHW-1:0] tag_ch [LAT];
    logic [CHW-1:0] fifo_ch  [FIFO_DEPTH];
    logic [7:0]     fifo_q   [FIFO_DEPTH];
    logic           fifo_sat [FIFO_DEPTH];
    logic [PW-1:0]  wr_ptr, rd_ptr;
    logic [CW-1:0]  count;
    logic [OW-1:0]  outstanding;
    logic [CHW-1:0] gnt, idx;
    logic           gnt_valid, credit, handshake, push, pop, cfg_ok;

    // Handshake rule: a transfer happens on a cycle where valid and ready are both
    // high at the rising edge; ready never looks at the consumer side in the same cycle.
    always_comb begin
        gnt_valid = 1'b0;
        gnt       = '0;
        idx       = '0;
        for (int i = 0; i < NCH; i++) begin
            idx = CHW'((int'(rr_ptr) + i) % NCH);
            if (!gnt_valid && req_valid[idx]) begin
                gnt_valid = 1'b1;
                gnt       = idx;
            end
        end
    end

    // Credits cover the issue register, every live tag and every FIFO entry.
    always_comb begin
        outstanding = OW'(qp_ena) + OW'(count);
        for (int i = 0; i < LAT; i++) outstanding = outstanding + OW'(tag_v[i]);
    end

    assign credit    = outstanding < OW'(FIFO_DEPTH);
    assign handshake = gnt_valid && credit;
    assign req_ready = handshake ? (NCH'(1) << gnt) : '0;
    assign cfg_ok    = 32'(cfg_ch) < NCH;
    assign push      = qp_out_valid && tag_v[LAT-1];
    assign pop       = res_valid && res_ready;
    assign busy      = outstanding != '0;
    assign res_valid = count != '0;
    assign res_ch    = fifo_ch[rd_ptr];
    assign res_q     = fifo_q[rd_ptr];
    assign res_sat   = fifo_sat[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NCH; i++) begin
                cfg_scale_r[i] <= SCALE_ONE;
                cfg_zp_r[i]    <= '0;
                cfg_asym_r[i]  <= 1'b0;
            end
        end else if (cfg_we && cfg_ok) begin
            cfg_scale_r[cfg_ch] <= cfg_scale;
            cfg_zp_r[cfg_ch]    <= cfg_zp;
            cfg_asym_r[cfg_ch]  <= cfg_asym;
        end
    end

    // Issue register samples the pre-write config, so a same-cycle write affects the next op.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr      <= '0;
            issue_ch    <= '0;
            qp_ena      <= 1'b0;
            qp_fp_in    <= '0;
            qp_scale    <= SCALE_ONE;
            qp_zp       <= '0;
            qp_use_asym <= 1'b0;
        end else begin
            qp_ena <= handshake;
            if (handshake) begin
                rr_ptr      <= CHW'((int'(gnt) + 1) % NCH);
                issue_ch    <= gnt;
                qp_fp_in    <= req_data[32*gnt +: 32];
                qp_scale    <= cfg_scale_r[gnt];
                qp_zp       <= cfg_zp_r[gnt];
                qp_use_asym <= cfg_asym_r[gnt];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LAT; i++) begin
                tag_v[i]  <= 1'b0;
                tag_ch[i] <= '0;
            end
            err <= 1'b0;
        end else begin
            tag_v[0]  <= qp_ena;
            tag_ch[0] <= issue_ch;
            for (int i = 1; i < LAT; i++) begin
                tag_v[i]  <= tag_v[i-1];
                tag_ch[i] <= tag_ch[i-1];
            end
            if (qp_out_valid != tag_v[LAT-1]) err <= 1'b1;
        end
    end

    // FIFO_DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_ch[i]  <= '0;
                fifo_q[i]   <= '0;
                fifo_sat[i] <= 1'b0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                fifo_ch[wr_ptr]  <= tag_ch[LAT-1];
                fifo_q[wr_ptr]   <= qp_q_out;
                fifo_sat[wr_ptr] <= qp_sat;
                wr_ptr           <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: tb/tb_quant_channel_scheduler.sv
// Directed bench for quant_channel_scheduler with a behavioural quantize_pipeline
// model, a table of single-op vectors and hand-written multi-cycle sequences.
module tb_quant_channel_scheduler;
    localparam int NCH = 4;
    localparam int CHW = 2;
    localparam int LAT = 4;
    localparam int FIFO_DEPTH = 8;
    localparam logic [31:0] ONE = 32'h3F80_0000;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              cfg_we = 1'b0;
    logic [CHW-1:0]    cfg_ch = '0;
    logic [31:0]       cfg_scale = '0;
    logic [7:0]        cfg_zp = '0;
    logic              cfg_asym = 1'b0;
    logic [NCH-1:0]    req_valid = '0;
    logic [NCH*32-1:0] req_data = '0;
    logic [NCH-1:0]    req_ready;
    logic              qp_ena, qp_use_asym;
    logic [31:0]       qp_fp_in, qp_scale;
    logic [7:0]        qp_zp, qp_q_out;
    logic              qp_sat, qp_out_valid;
    logic              res_valid, res_ready = 1'b1;
    logic [CHW-1:0]    res_ch;
    logic [7:0]        res_q;
    logic              res_sat, busy, err;

    int n_checks = 0;
    int n_fail = 0;
    logic [10:0] exp_q[$];
    logic [10:0] mon_e;
    logic mon_en = 1'b0;
    logic inject = 1'b0;

    always #5 clk = ~clk;

    quant_channel_scheduler #(.NCH(NCH), .CHW(CHW), .LAT(LAT), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_scale(cfg_scale),
        .cfg_zp(cfg_zp), .cfg_asym(cfg_asym), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .qp_ena(qp_ena), .qp_fp_in(qp_fp_in), .qp_scale(qp_scale),
        .qp_zp(qp_zp), .qp_use_asym(qp_use_asym), .qp_q_out(qp_q_out), .qp_sat(qp_sat),
        .qp_out_valid(qp_out_valid), .res_valid(res_valid), .res_ready(res_ready),
        .res_ch(res_ch), .res_q(res_q), .res_sat(res_sat), .busy(busy), .err(err)
    );

    // Pipeline model: round(fp*scale), +zp and clamp to [0,255] when asym, else clamp to [-128,127].
    function automatic real f2r(input logic [31:0] b);
        int e;
        real m;
        e = int'(b[30:23]);
        if (e == 0) return 0.0;
        m = (1.0 + real'(b[22:0]) / 8388608.0) * (2.0 ** (e - 127));
        return b[31] ? -m : m;
    endfunction

    function automatic logic [8:0] quant(input logic [31:0] fp, input logic [31:0] sc,
                                         input logic [7:0] zp, input logic asym);
        real p;
        int r, v, lo, hi;
        logic s;
        p = f2r(fp) * f2r(sc);
        if (p > 1000.0) p = 1000.0;
        if (p < -1000.0) p = -1000.0;
        r = (p >= 0.0) ? $rtoi(p + 0.5) : -$rtoi(-p + 0.5);
        v = asym ? r + int'(zp) : r;
        lo = asym ? 0 : -128;
        hi = asym ? 255 : 127;
        s = 1'b0;
        if (v > hi) begin v = hi; s = 1'b1; end
        if (v < lo) begin v = lo; s = 1'b1; end
        return {s, 8'(v)};
    endfunction

    logic       mv [LAT];
    logic [8:0] md [LAT];
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LAT; i++) begin mv[i] <= 1'b0; md[i] <= '0; end
        end else begin
            mv[0] <= qp_ena;
            md[0] <= quant(qp_fp_in, qp_scale, qp_zp, qp_use_asym);
            for (int i = 1; i < LAT; i++) begin mv[i] <= mv[i-1]; md[i] <= md[i-1]; end
        end
    end
    assign qp_out_valid = mv[LAT-1] | inject;
    assign qp_q_out = md[LAT-1][7:0];
    assign qp_sat = md[LAT-1][8];

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard: results must match the expected queue in issue order.
    always @(negedge clk) begin
        if (mon_en && rst_n && res_valid && res_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_result: got %h expected none", {res_ch, res_q, res_sat});
            end else begin
                mon_e = exp_q.pop_front();
                check("result_order", {res_ch, res_q, res_sat}, mon_e);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic write_cfg(input logic [CHW-1:0] ch, input logic [31:0] sc,
                             input logic [7:0] zp, input logic asym);
        cfg_we = 1'b1; cfg_ch = ch; cfg_scale = sc; cfg_zp = zp; cfg_asym = asym;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 80 && exp_q.size() != 0; i++) tick();
        check("drain_empty", 96'(exp_q.size()), 96'd0);
    endtask

    typedef struct {
        logic [CHW-1:0] ch;
        logic [31:0]    scale;
        logic [7:0]     zp;
        logic           asym;
        logic [31:0]    fp;
        logic [7:0]     q;
        logic           sat;
    } vec_t;
    vec_t vecs[4];

    initial begin
        int lat, hs, seen;
        vecs[0] = '{ch: 2'd1, scale: 32'h4000_0000, zp: 8'd10, asym: 1'b1, fp: 32'h4148_0000, q: 8'd35,   sat: 1'b0};
        vecs[1] = '{ch: 2'd2, scale: 32'h3F80_0000, zp: 8'd0,  asym: 1'b0, fp: 32'h4700_0000, q: 8'd127,  sat: 1'b1};
        vecs[2] = '{ch: 2'd3, scale: 32'h4080_0000, zp: 8'd5,  asym: 1'b1, fp: 32'hC1A0_0000, q: 8'd0,    sat: 1'b1};
        vecs[3] = '{ch: 2'd0, scale: 32'h3F00_0000, zp: 8'd0,  asym: 1'b0, fp: 32'hC100_0000, q: 8'hFC,   sat: 1'b0};

        do_reset();
        sample();
        check("reset_issue", {req_ready, qp_ena, qp_fp_in, qp_scale, qp_zp, qp_use_asym},
              {4'b0, 1'b0, 32'h0, ONE, 8'h0, 1'b0});
        check("reset_result", {res_valid, res_ch, res_q, res_sat, busy, err}, 96'd0);

        for (int v = 0; v < 4; v++) begin
            tick();
            write_cfg(vecs[v].ch, vecs[v].scale, vecs[v].zp, vecs[v].asym);
            req_data = '0;
            req_data[32*vecs[v].ch +: 32] = vecs[v].fp;
            req_valid = NCH'(1) << vecs[v].ch;
            sample();
            check("vec_ready", req_ready, NCH'(1) << vecs[v].ch);
            tick();
            req_valid = '0;
            sample();
            check("vec_issue", {qp_ena, qp_fp_in, qp_scale, qp_zp, qp_use_asym},
                  {1'b1, vecs[v].fp, vecs[v].scale, vecs[v].zp, vecs[v].asym});
            lat = 1;
            while (!res_valid && lat < 20) begin
                tick();
                sample();
                lat++;
            end
            check("vec_latency", 96'(lat), 96'(2 + LAT));
            check("vec_result", {res_ch, res_q, res_sat}, {vecs[v].ch, vecs[v].q, vecs[v].sat});
        end
        tick();

        // Round robin with all channels requesting; operand of channel i is (i+1).0
        do_reset();
        mon_en = 1'b1;
        req_data = {32'h4080_0000, 32'h4040_0000, 32'h4000_0000, ONE};
        req_valid = '1;
        for (int k = 0; k < 8; k++) begin
            sample();
            check("rr_grant", req_ready, NCH'(1) << (k % 4));
            exp_q.push_back({2'(k % 4), 8'(k % 4 + 1), 1'b0});
            tick();
        end
        req_valid = '0;
        wait_drain();
        repeat (3) tick();
        sample();
        check("rr_idle", {busy, res_valid, err}, 96'd0);
        tick();

        // Backpressure: credits must stop issue at FIFO_DEPTH outstanding
        do_reset();
        res_ready = 1'b0;
        req_valid = '1;
        hs = 0;
        for (int c = 0; c < 20; c++) begin
            sample();
            if (req_ready != '0) begin
                check("bp_grant", req_ready, NCH'(1) << (hs % 4));
                exp_q.push_back({2'(hs % 4), 8'(hs % 4 + 1), 1'b0});
                hs++;
            end
            tick();
        end
        check("bp_handshakes", 96'(hs), 96'd8);
        sample();
        check("bp_stall", {req_ready, busy, res_valid}, {4'b0, 1'b1, 1'b1});
        tick();
        res_ready = 1'b1;
        for (int c = 0; c < 30; c++) begin
            sample();
            if (req_ready != '0) begin
                check("bp_grant", req_ready, NCH'(1) << (hs % 4));
                exp_q.push_back({2'(hs % 4), 8'(hs % 4 + 1), 1'b0});
                hs++;
            end
            tick();
        end
        req_valid = '0;
        check("bp_resumed", 96'(hs > 16), 96'd1);
        wait_drain();
        tick();

        // Config write racing a handshake on the same channel
        do_reset();
        write_cfg(2'd0, ONE, 8'd10, 1'b1);
        exp_q.push_back({2'd0, 8'd11, 1'b0});
        exp_q.push_back({2'd0, 8'd21, 1'b0});
        req_data = '0;
        req_data[31:0] = ONE;
        req_valid = 4'b0001;
        cfg_we = 1'b1; cfg_ch = 2'd0; cfg_scale = ONE; cfg_zp = 8'd20; cfg_asym = 1'b1;
        sample();
        check("race_ready0", req_ready, 4'b0001);
        tick();
        cfg_we = 1'b0;
        sample();
        check("race_old_cfg", {qp_ena, qp_zp, req_ready}, {1'b1, 8'd10, 4'b0001});
        tick();
        req_valid = '0;
        sample();
        check("race_new_cfg", {qp_ena, qp_zp}, {1'b1, 8'd20});
        wait_drain();
        repeat (3) tick();

        // Spurious pipeline valid with no tag in flight
        sample();
        check("err_clear", 96'(err), 96'd0);
        tick();
        inject = 1'b1;
        tick();
        inject = 1'b0;
        sample();
        check("err_set", 96'(err), 96'd1);
        check("err_no_push", {res_valid, busy}, 96'd0);
        repeat (5) tick();
        sample();
        check("err_sticky", 96'(err), 96'd1);
        tick();

        // Asynchronous reset in the middle of traffic
        do_reset();
        req_data = {32'h4080_0000, 32'h4040_0000, 32'h4000_0000, ONE};
        req_valid = '1;
        repeat (3) tick();
        #2;
        req_valid = '0;
        rst_n = 1'b0;
        #1;
        check("async_clear", {qp_ena, res_valid, busy, err, req_ready, qp_scale},
              {1'b0, 1'b0, 1'b0, 1'b0, 4'b0, ONE});
        @(posedge clk);
        #1 rst_n = 1'b1;
        seen = 0;
        for (int c = 0; c < 12; c++) begin
            sample();
            if (res_valid) seen++;
            tick();
        end
        check("no_res_after_reset", 96'(seen), 96'd0);
        check("no_err_after_reset", {err, busy}, 96'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
